// File: rtl/busca_pc_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
// The fetch stage is the master; the memory model or bus bridge is the slave.
interface busca_pc_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_data
   );
endinterface

// File: rtl/busca_pc.sv
// MIPS instruction-fetch / program-counter stage: fetches one instruction per
// BUSCA/EXEC pair and picks the next PC (sequential, branch or jump).
module busca_pc #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        resultado,
   input  logic        jump,
   input  logic [15:0] imediato,
   input  logic [25:0] jump_addr,
   input  logic        stall,
   busca_pc_if.master  imem,
   output logic [31:0] instrucao,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_mais4
);

   typedef enum logic [1:0] {INICIO, BUSCA, EXEC} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] instr_q;
   logic        req_q;
   logic        valid_q;

   // Jump outranks a taken branch; all adds wrap modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] seq,
                                           input logic        br,
                                           input logic        jmp,
                                           input logic [15:0] imm,
                                           input logic [25:0] jaddr);
      logic [31:0] off;
      off = {{14{imm[15]}}, imm, 2'b00};
      if (jmp)
         return {seq[31:28], jaddr, 2'b00};
      else if (br)
         return seq + off;
      else
         return seq;
   endfunction

   assign pc_mais4 = pc_q + 32'd4;
   assign pc_d     = next_pc(pc_mais4, resultado, jump, imediato, jump_addr);

   // req/valid are registered alongside the state so they never glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INICIO;
         pc_q    <= PC_RESET;
         instr_q <= 32'h0000_0000;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            INICIO: begin
               state_q <= BUSCA;
               req_q   <= 1'b1;
            end
            BUSCA: begin
               if (imem.imem_ready) begin
                  instr_q <= imem.imem_data;
                  state_q <= EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  pc_q    <= pc_d;
                  state_q <= BUSCA;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= INICIO;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instrucao      = instr_q;
   assign instr_valid    = valid_q;
   assign pc             = pc_q;

endmodule

// File: doc/busca_pc.md
# busca_pc

Instruction-fetch and program-counter stage of the MIPS processor. It holds the PC, fetches instructions from instruction memory through a request/ready handshake, and presents each instruction to decode/execute. It consumes the branch decision `resultado` from `portaAND` and the control unit's `jump`, then selects the next PC: sequential, branch target or jump target.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `resultado`  in  1: branch-taken decision from `portaAND`; sampled only in EXEC.
- `jump`  in  1: jump control from the control unit; sampled only in EXEC.
- `imediato`  in  16: branch offset field, instruction[15:0].
- `jump_addr`  in  26: jump target field, instruction[25:0].
- `stall`  in  1: hold the current instruction in EXEC.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; always equals `pc`.
- `imem_ready`  in  1: memory has valid data on `imem_data` this cycle.
- `imem_data`  in  32: instruction word from memory.
- `instrucao`  out  32: registered fetched instruction.
- `instr_valid`  out  1: `instrucao` is valid for decode/execute.
- `pc`  out  32: current PC register.
- `pc_mais4`  out  32: combinational `pc + 4`.

## Operation
- FSM states: INICIO, BUSCA, EXEC. The reset state is INICIO.
- **INICIO**
  - `imem_req`=0.
  - Next edge goes to BUSCA unconditionally.
- **BUSCA**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ready`=1: latch `imem_data` into `instrucao` and go to EXEC.
  - Otherwise stay in BUSCA with the request held and the PC unchanged.
- **EXEC**
  - `instr_valid`=1 and `imem_req`=0.
  - Downstream logic derives `resultado`, `jump`, `imediato` and `jump_addr` from `instrucao` in this cycle.
  - `stall`=1: stay in EXEC. PC and `instrucao` hold, and `instr_valid` stays 1.
  - `stall`=0: on the edge, load the next PC and go to BUSCA.
- Next-PC priority (highest first):
  - `jump`=1: {`pc_mais4`[31:28], `jump_addr`, 2'b00}.
  - `resultado`=1: `pc_mais4` + ({{14{`imediato`[15]}}, `imediato`, 2'b00}).
  - Otherwise: `pc_mais4`.
- Arithmetic: all adds are 32-bit unsigned, modulo 2^32. Carries are discarded.
  - `pc`=32'hFFFF_FFFC, sequential: next PC is 32'h0000_0000.
- Outputs and inputs by state:
  - `imem_req` and `instr_valid` are decoded from the registered state only, so they are glitch-free.
  - `imem_ready` is ignored outside BUSCA.
  - `resultado`, `jump` and `stall` are ignored outside EXEC.
- Handshake rules:
  - Memory must hold `imem_data` stable while `imem_ready`=1.
  - This block never drops `imem_req` before ready, except on reset.
- Reset values:
  - `pc`=`PC_RESET`
  - `instrucao`=0
  - state=INICIO
  - `instr_valid`=0
  - `imem_req`=0
  - `imem_addr`=`PC_RESET`
  - `pc_mais4`=`PC_RESET`+4
- Reset mid-operation (any state, including BUSCA with ready pending): outputs go to their reset values immediately, without waiting for a clock edge. A pending fetch is abandoned, and the memory must tolerate the request dropping.

## Timing
- After `reset_n` rises:
  - first edge: INICIO→BUSCA;
  - `imem_req` is high from the cycle after that edge.
- Fetch latency with zero wait states:
  - the edge on which `imem_ready`=1 in BUSCA loads `instrucao`;
  - `instr_valid` is high in the following cycle.
- Throughput: at best one instruction per 2 cycles (BUSCA + EXEC). Each wait state on `imem_ready` adds 1 cycle.
- PC update happens exactly on the EXEC→BUSCA edge. `imem_addr` shows the new PC in the first BUSCA cycle after it.
- `pc_mais4` and the next-PC mux are combinational from `pc`, with no extra latency.

## Test plan
- **Reset and first fetch:** `PC_RESET`=32'h0040_0000, `imem_ready` tied 1 → `imem_req` rises 1 cycle after reset release with `imem_addr`=32'h0040_0000; `instr_valid` pulses after the next edge with `instrucao`=`imem_data`.
- **Sequential and wait states:** `imem_ready` held low for 3 BUSCA cycles → `imem_req` and `imem_addr` held for 3 cycles; after EXEC with no branch, PC=old+4.
- **Taken branch, negative offset:** `pc`=32'h0000_0100, `resultado`=1, `imediato`=16'hFFFE → next `pc`=32'h0000_00FC. With `resultado`=0 → 32'h0000_0104.
- **Jump priority:** `pc`=32'h1000_0000, `jump`=1, `resultado`=1, `jump_addr`=26'h000_0040 → next `pc`=32'h1000_0100.
- **Stall:** `stall`=1 for 4 EXEC cycles → `pc`, `instrucao` and `instr_valid`=1 hold, `imem_req`=0; PC updates only on the first edge with `stall`=0.
- **Reset mid-fetch and wrap:**
  - `reset_n` pulled low in BUSCA → `imem_req`=0 and `pc`=`PC_RESET` before the next edge.
  - `pc`=32'hFFFF_FFFC sequential → next `pc`=32'h0000_0000.
